// File: rtl/vga_scan_timing.sv
// VGA raster scan generator: pixel divider, x/y counters, blanking,
// frame strobe/counter and pipelined hs/vs aligned to a registered colour.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   pixel_x      horizontal count 0..H_TOTAL-1
//   pixel_y      vertical count 0..V_TOTAL-1
//   vedio_on     coordinate lies in the visible window
//   vblank       pixel_y is in vertical blanking
//   pix_tick     one-clk strobe on the first cycle of each coordinate
//   frame_start  one-clk strobe on the first cycle of (0,0)
//   frame_cnt    frames started since reset (wrapping)
//   hs, vs       syncs delayed by PIPE_DELAY pixel ticks
module vga_scan_timing #(
    parameter int   CLK_DIV     = 4,
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIPE_DELAY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        vedio_on,
    output logic        vblank,
    output logic        pix_tick,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        hs,
    output logic        vs
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam int PW = PIPE_DELAY + 1;

    logic [3:0]    r_div;
    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic          r_von;
    logic          r_vblank;
    logic          r_tick;
    logic          r_fs;
    logic [15:0]   r_fcnt;
    logic [PW-1:0] r_hs_pipe;
    logic [PW-1:0] r_vs_pipe;

    logic          w_adv;
    logic [9:0]    w_nx;
    logic [9:0]    w_ny;
    logic          w_hs_raw;
    logic          w_vs_raw;
    logic          w_origin;

    // Everything below is decoded from the coordinate the counters move
    // to on this edge, so registered flags line up with the coordinates.
    always_comb begin
        w_adv = (r_div == DIV_LAST);
        w_nx  = r_x + 10'd1;
        w_ny  = r_y;
        if (r_x == H_LAST) begin
            w_nx = 10'd0;
            if (r_y == V_LAST) begin
                w_ny = 10'd0;
            end else begin
                w_ny = r_y + 10'd1;
            end
        end
        w_origin = (w_nx == 10'd0) && (w_ny == 10'd0);
        w_hs_raw = ((w_nx >= HS_BEG) && (w_nx < HS_END)) ?
                   SYNC_ACTIVE : ~SYNC_ACTIVE;
        w_vs_raw = ((w_ny >= VS_BEG) && (w_ny < VS_END)) ?
                   SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div     <= 4'd0;
            r_x       <= H_LAST;
            r_y       <= V_LAST;
            r_von     <= 1'b0;
            r_vblank  <= 1'b1;
            r_tick    <= 1'b0;
            r_fs      <= 1'b0;
            r_fcnt    <= 16'd0;
            r_hs_pipe <= {PW{~SYNC_ACTIVE}};
            r_vs_pipe <= {PW{~SYNC_ACTIVE}};
        end else begin
            r_tick <= w_adv;
            r_fs   <= w_adv && w_origin;
            if (w_adv) begin
                r_div    <= 4'd0;
                r_x      <= w_nx;
                r_y      <= w_ny;
                r_von    <= (w_nx < H_VIS) && (w_ny < V_VIS);
                r_vblank <= (w_ny >= V_VIS);
                if (w_origin) begin
                    r_fcnt <= r_fcnt + 16'd1;
                end
                // Stage 0 holds the sync for the new coordinate; the
                // tap at PIPE_DELAY is that value PIPE_DELAY ticks later.
                r_hs_pipe <= (r_hs_pipe << 1) | PW'(w_hs_raw);
                r_vs_pipe <= (r_vs_pipe << 1) | PW'(w_vs_raw);
            end else begin
                r_div <= r_div + 4'd1;
            end
        end
    end

    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign vedio_on    = r_von;
    assign vblank      = r_vblank;
    assign pix_tick    = r_tick;
    assign frame_start = r_fs;
    assign frame_cnt   = r_fcnt;
    assign hs          = r_hs_pipe[PIPE_DELAY];
    assign vs          = r_vs_pipe[PIPE_DELAY];

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench for vga_scan_timing: default timing instance, a
// reduced-size instance (CLK_DIV=2) and a reduced CLK_DIV=1 instance.
module tb_vga_scan_timing;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [9:0]  d_x, d_y, s_x, s_y, o_x, o_y;
    logic        d_von, d_vb, d_tick, d_fs, d_hs, d_vs;
    logic        s_von, s_vb, s_tick, s_fs, s_hs, s_vs;
    logic        o_von, o_vb, o_tick, o_fs, o_hs, o_vs;
    logic [15:0] d_fc, s_fc, o_fc;

    int checks = 0;
    int errs   = 0;

    vga_scan_timing u_def (
        .clk(clk), .rst(rst),
        .pixel_x(d_x), .pixel_y(d_y),
        .vedio_on(d_von), .vblank(d_vb),
        .pix_tick(d_tick), .frame_start(d_fs),
        .frame_cnt(d_fc), .hs(d_hs), .vs(d_vs)
    );

    // H_TOTAL=15 (hs x 10..12), V_TOTAL=8 (vs y 5..6), 240 clk frame
    vga_scan_timing #(
        .CLK_DIV(2),
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_sml (
        .clk(clk), .rst(rst),
        .pixel_x(s_x), .pixel_y(s_y),
        .vedio_on(s_von), .vblank(s_vb),
        .pix_tick(s_tick), .frame_start(s_fs),
        .frame_cnt(s_fc), .hs(s_hs), .vs(s_vs)
    );

    // Same raster with CLK_DIV=1: 120 clk frame
    vga_scan_timing #(
        .CLK_DIV(1),
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_one (
        .clk(clk), .rst(rst),
        .pixel_x(o_x), .pixel_y(o_y),
        .vedio_on(o_von), .vblank(o_vb),
        .pix_tick(o_tick), .frame_start(o_fs),
        .frame_cnt(o_fc), .hs(o_hs), .vs(o_vs)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_x(input int tgt, input int bound,
                          input string tag);
        int n;
        n = 0;
        while (32'(d_x) != tgt && n < bound) begin
            step(1);
            n++;
        end
        chk(tag, 32'(d_x), tgt);
    endtask

    int n, c, vbc, vsl, hsl, ofs, ofirst, dfirst, dfc, ticklo;
    int vsx, vsy, hsx, hsy, vbx, vby, prev_vb;

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", 32'(d_x), 799);
        chk("rst_y", 32'(d_y), 524);
        chk("rst_von", 32'(d_von), 0);
        chk("rst_vblank", 32'(d_vb), 1);
        chk("rst_hs", 32'(d_hs), 1);
        chk("rst_vs", 32'(d_vs), 1);
        chk("rst_fcnt", 32'(d_fc), 0);
        chk("rst_tick", 32'(d_tick), 0);
        chk("rst_fs", 32'(d_fs), 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- first frame: 4th edge lands on (0,0) ----
        step(3);
        chk("pre_x", 32'(d_x), 799);
        chk("pre_tick", 32'(d_tick), 0);
        step(1);
        chk("ff_x", 32'(d_x), 0);
        chk("ff_y", 32'(d_y), 0);
        chk("ff_von", 32'(d_von), 1);
        chk("ff_vblank", 32'(d_vb), 0);
        chk("ff_tick", 32'(d_tick), 1);
        chk("ff_fs", 32'(d_fs), 1);
        chk("ff_fcnt", 32'(d_fc), 1);
        step(1);
        chk("ff_tick_lo", 32'(d_tick), 0);
        chk("ff_fs_lo", 32'(d_fs), 0);
        chk("ff_hold_x", 32'(d_x), 0);

        // ---- visible edge ----
        wait_x(638, 4000, "wait_638");
        chk("von_638", 32'(d_von), 1);
        step(4);
        chk("x_639", 32'(d_x), 639);
        chk("von_639", 32'(d_von), 1);
        chk("tick_639", 32'(d_tick), 1);
        step(4);
        chk("x_640", 32'(d_x), 640);
        chk("von_640", 32'(d_von), 0);

        // ---- hs timing ----
        wait_x(656, 200, "wait_656");
        chk("hs_656", 32'(d_hs), 1);
        step(4);
        chk("x_657", 32'(d_x), 657);
        chk("hs_657", 32'(d_hs), 0);
        n = 0;
        while (d_hs == 1'b0 && n < 1000) begin
            step(1);
            n++;
        end
        chk("hs_low_clks", n, 384);
        chk("hs_rise_x", 32'(d_x), 753);

        // ---- line wrap and ticks per line ----
        wait_x(799, 400, "wait_799");
        chk("y_before_wrap", 32'(d_y), 0);
        step(4);
        chk("wrap_x", 32'(d_x), 0);
        chk("wrap_y", 32'(d_y), 1);
        chk("wrap_von", 32'(d_von), 1);
        chk("wrap_vblank", 32'(d_vb), 0);
        n = 0;
        c = 0;
        while (c < 4000) begin
            step(1);
            c++;
            if (d_tick) n++;
            if (d_tick && d_x == 10'd0) break;
        end
        chk("ticks_per_line", n, 800);
        chk("line2_y", 32'(d_y), 2);

        // ---- reset mid-frame at small (5,2) ----
        n = 0;
        while (!(s_x == 10'd5 && s_y == 10'd2) && n < 400) begin
            step(1);
            n++;
        end
        chk("mid_x", 32'(s_x), 5);
        chk("mid_y", 32'(s_y), 2);
        rst = 1'b1;
        #1;
        chk("mr_x", 32'(s_x), 14);
        chk("mr_y", 32'(s_y), 7);
        chk("mr_von", 32'(s_von), 0);
        chk("mr_vblank", 32'(s_vb), 1);
        chk("mr_fcnt", 32'(s_fc), 0);
        chk("mr_hs", 32'(s_hs), 1);
        chk("mr_vs", 32'(s_vs), 1);
        chk("mr_def_x", 32'(d_x), 799);
        chk("mr_def_fcnt", 32'(d_fc), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        step(1);
        chk("one_x", 32'(o_x), 0);
        chk("one_tick", 32'(o_tick), 1);
        chk("one_fs", 32'(o_fs), 1);
        chk("one_fcnt", 32'(o_fc), 1);
        chk("sml_hold_x", 32'(s_x), 14);
        chk("sml_tick_lo", 32'(s_tick), 0);
        step(1);
        chk("sml_x", 32'(s_x), 0);
        chk("sml_y", 32'(s_y), 0);
        chk("sml_fs", 32'(s_fs), 1);
        chk("sml_fcnt", 32'(s_fc), 1);
        chk("one_x2", 32'(o_x), 1);
        chk("one_fs_lo", 32'(o_fs), 0);

        // ---- one full small frame ----
        c = 0; vbc = 0; vsl = 0; hsl = 0; ofs = 0; ticklo = 0;
        ofirst = -1; dfirst = -1; dfc = -1;
        vsx = -1; vsy = -1; hsx = -1; hsy = -1; vbx = -1; vby = -1;
        prev_vb = -1;
        while (c < 1000) begin
            if (s_vb) begin
                vbc++;
                if (vby < 0) begin vbx = 32'(s_x); vby = 32'(s_y); end
            end
            if (!s_vs) begin
                vsl++;
                if (vsy < 0) begin vsx = 32'(s_x); vsy = 32'(s_y); end
            end
            if (!s_hs) begin
                hsl++;
                if (hsy < 0) begin hsx = 32'(s_x); hsy = 32'(s_y); end
            end
            if (o_fs) begin
                ofs++;
                if (ofirst < 0) ofirst = c;
            end
            if (!o_tick) ticklo++;
            if (d_fs && dfirst < 0) begin
                dfirst = c;
                dfc = 32'(d_fc);
            end
            prev_vb = 32'(s_vb);
            step(1);
            c++;
            if (s_fs) break;
        end
        chk("frame_clks", c, 240);
        chk("vblank_clks", vbc, 120);
        chk("vblank_rise_x", vbx, 0);
        chk("vblank_rise_y", vby, 4);
        chk("vblank_before_fs", prev_vb, 1);
        chk("vblank_at_fs", 32'(s_vb), 0);
        chk("vs_low_clks", vsl, 60);
        chk("vs_fall_x", vsx, 1);
        chk("vs_fall_y", vsy, 5);
        chk("hs_low_clks_sml", hsl, 48);
        chk("hs_fall_x_sml", hsx, 11);
        chk("hs_fall_y_sml", hsy, 0);
        chk("fcnt_2nd", 32'(s_fc), 2);
        chk("fs_pos_x", 32'(s_x), 0);
        chk("fs_pos_y", 32'(s_y), 0);
        chk("one_fs_count", ofs, 2);
        chk("one_fs_first", ofirst, 119);
        chk("one_tick_low", ticklo, 0);
        chk("def_fs_after_rst", dfirst, 2);
        chk("def_fcnt_after_rst", dfc, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errs);
        $finish;
    end

endmodule
